// File: rtl/cnn_pkg.sv
// rtl/cnn_pkg.sv - shared widths, limits and saturating add for the CNN datapath
package cnn_pkg;

  // Largest kernel edge the window generator can deliver.
  localparam int MAX_KERNEL_SIZE = 7;

  // Saturating add result: clamp flag plus the clamped value in 64-bit form.
  typedef struct packed {
    logic               sat;
    logic signed [63:0] val;
  } sat_t;

  // Width of one unsigned-feature by signed-weight product.
  function automatic int prod_width(input int dw);
    return 2 * dw;
  endfunction

  // Width of the reduced KxK product sum; wide enough that it cannot overflow.
  function automatic int tree_width(input int dw, input int k);
    return 2 * dw + $clog2(k * k);
  endfunction

  // Add two sign-extended operands and clamp to a signed w-bit range (w <= 63).
  function automatic sat_t sat_add(input logic signed [63:0] a,
                                   input logic signed [63:0] b,
                                   input int w);
    logic signed [63:0] s;
    logic signed [63:0] hi;
    logic signed [63:0] lo;
    sat_t r;
    s  = a + b;
    hi = (64'sd1 <<< (w - 1)) - 64'sd1;
    lo = -(64'sd1 <<< (w - 1));
    r.sat = 1'b0;
    r.val = s;
    if (s > hi) begin
      r.sat = 1'b1;
      r.val = hi;
    end else if (s < lo) begin
      r.sat = 1'b1;
      r.val = lo;
    end
    return r;
  endfunction

endpackage

// File: rtl/mac_adder_tree.sv
// rtl/mac_adder_tree.sv - recursive balanced signed adder tree with optional output register
module mac_adder_tree #(
  parameter int N          = 9,
  parameter int IW         = 16,
  parameter int OW         = IW + $clog2(N),
  parameter bit REGISTERED = 1'b1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 en,
  input  logic [N*IW-1:0]      din,
  output logic signed [OW-1:0] dout
);

  logic signed [OW-1:0] sum_c;

  generate
    if (N == 1) begin : g_leaf
      assign sum_c = OW'(signed'(din[IW-1:0]));
    end else begin : g_split
      // Lower half gets floor(N/2) terms so odd counts fall naturally into the upper half.
      localparam int NL  = N / 2;
      localparam int NH  = N - NL;
      localparam int OWL = IW + $clog2(NL);
      localparam int OWH = IW + $clog2(NH);

      logic signed [OWL-1:0] lo_sum;
      logic signed [OWH-1:0] hi_sum;

      mac_adder_tree #(
        .N(NL), .IW(IW), .OW(OWL), .REGISTERED(1'b0)
      ) u_lo (
        .clk  (clk),
        .rst  (rst),
        .en   (en),
        .din  (din[NL*IW-1:0]),
        .dout (lo_sum)
      );

      mac_adder_tree #(
        .N(NH), .IW(IW), .OW(OWH), .REGISTERED(1'b0)
      ) u_hi (
        .clk  (clk),
        .rst  (rst),
        .en   (en),
        .din  (din[N*IW-1:NL*IW]),
        .dout (hi_sum)
      );

      assign sum_c = OW'(lo_sum) + OW'(hi_sum);
    end

    if (REGISTERED) begin : g_reg
      // Capture the full sum; hold it while the pipeline is stalled.
      always_ff @(posedge clk) begin
        if (rst) begin
          dout <= '0;
        end else if (en) begin
          dout <= sum_c;
        end
      end
    end else begin : g_comb
      logic unused_ctrl;
      assign unused_ctrl = clk ^ rst ^ en;
      assign dout = sum_c;
    end
  endgenerate

endmodule

// File: rtl/mac_pipelined.sv
// rtl/mac_pipelined.sv - three-stage KxK MAC with channel accumulation, bias and saturation
module mac_pipelined
  import cnn_pkg::*;
#(
  parameter int KERNEL_SIZE = 3,
  parameter int DATA_WIDTH  = 8,
  parameter int ACC_WIDTH   = 32
) (
  input  logic                                        clk,
  input  logic                                        rst,
  input  logic                                        in_valid,
  output logic                                        in_ready,
  input  logic                                        in_first,
  input  logic                                        in_last,
  input  logic [KERNEL_SIZE*KERNEL_SIZE*DATA_WIDTH-1:0] feature,
  input  logic [KERNEL_SIZE*KERNEL_SIZE*DATA_WIDTH-1:0] kernel,
  input  logic signed [ACC_WIDTH-1:0]                 bias,
  output logic                                        out_valid,
  input  logic                                        out_ready,
  output logic signed [ACC_WIDTH-1:0]                 result,
  output logic                                        out_sat
);

  localparam int NT = KERNEL_SIZE * KERNEL_SIZE;
  localparam int PW = prod_width(DATA_WIDTH);
  localparam int TW = tree_width(DATA_WIDTH, KERNEL_SIZE);

  // The whole pipeline moves only when the output register is free or being drained.
  logic adv;
  assign adv      = !(out_valid && !out_ready);
  assign in_ready = adv;

  // Per-element products: zero-extend the pixel, sign-extend the weight, multiply at product width.
  logic [NT*PW-1:0] prod_c;

  genvar gi;
  generate
    for (gi = 0; gi < NT; gi++) begin : g_mul
      logic signed [PW-1:0] fx;
      logic signed [PW-1:0] wx;
      logic signed [PW-1:0] p;
      assign fx = PW'(signed'({1'b0, feature[gi*DATA_WIDTH +: DATA_WIDTH]}));
      assign wx = PW'(signed'(kernel[gi*DATA_WIDTH +: DATA_WIDTH]));
      assign p  = fx * wx;
      assign prod_c[gi*PW +: PW] = p;
    end
  endgenerate

  logic                        s1_valid;
  logic                        s1_first;
  logic                        s1_last;
  logic signed [ACC_WIDTH-1:0] s1_bias;
  logic [NT*PW-1:0]            s1_prod;

  // S1: register products together with the beat's flags and bias.
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid <= 1'b0;
      s1_first <= 1'b0;
      s1_last  <= 1'b0;
      s1_bias  <= '0;
      s1_prod  <= '0;
    end else if (adv) begin
      s1_valid <= in_valid;
      s1_first <= in_first;
      s1_last  <= in_last;
      s1_bias  <= bias;
      s1_prod  <= prod_c;
    end
  end

  logic                        s2_valid;
  logic                        s2_first;
  logic                        s2_last;
  logic signed [ACC_WIDTH-1:0] s2_bias;
  logic signed [TW-1:0]        s2_sum;

  mac_adder_tree #(
    .N(NT), .IW(PW), .OW(TW), .REGISTERED(1'b1)
  ) u_tree (
    .clk  (clk),
    .rst  (rst),
    .en   (adv),
    .din  (s1_prod),
    .dout (s2_sum)
  );

  // S2: carry side-band alongside the registered tree sum.
  always_ff @(posedge clk) begin
    if (rst) begin
      s2_valid <= 1'b0;
      s2_first <= 1'b0;
      s2_last  <= 1'b0;
      s2_bias  <= '0;
    end else if (adv) begin
      s2_valid <= s1_valid;
      s2_first <= s1_first;
      s2_last  <= s1_last;
      s2_bias  <= s1_bias;
    end
  end

  logic signed [ACC_WIDTH-1:0] acc;
  logic                        sticky;
  logic                        grp_open;

  logic                        s3_start;
  logic signed [ACC_WIDTH-1:0] s3_base;
  logic                        s3_clamp;
  logic [63-ACC_WIDTH:0]       sat_hi_unused;
  logic signed [ACC_WIDTH-1:0] s3_val;
  logic                        s3_sticky;

  // S3 next value: a beat with no open group starts a fresh group, from bias only when flagged first.
  always_comb begin
    s3_start = s2_first || !grp_open;
    if (s2_first) begin
      s3_base = s2_bias;
    end else if (grp_open) begin
      s3_base = acc;
    end else begin
      s3_base = '0;
    end
    {s3_clamp, sat_hi_unused, s3_val} = sat_add(64'(s3_base), 64'(s2_sum), ACC_WIDTH);
    s3_sticky = (s3_start ? 1'b0 : sticky) | s3_clamp;
  end

  // S3 state and output register: accumulate, close group on last, drain on handshake.
  always_ff @(posedge clk) begin
    if (rst) begin
      acc       <= '0;
      sticky    <= 1'b0;
      grp_open  <= 1'b0;
      out_valid <= 1'b0;
      result    <= '0;
      out_sat   <= 1'b0;
    end else begin
      if (adv && s2_valid) begin
        acc      <= s3_val;
        sticky   <= s3_sticky;
        grp_open <= !s2_last;
        if (s2_last) begin
          result  <= s3_val;
          out_sat <= s3_sticky;
        end
      end
      if (adv && s2_valid && s2_last) begin
        out_valid <= 1'b1;
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_mac_pipelined.sv
// tb/tb_mac_pipelined.sv - directed vector bench for mac_pipelined
module tb_mac_pipelined;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic rst;

  // main instance: K=3, ACC=32
  logic               in_valid, in_ready, in_first, in_last, out_valid, out_ready, out_sat;
  logic [71:0]        feature, kernel;
  logic signed [31:0] bias, result;

  // K=5 instance
  logic               k5_valid, k5_in_ready, k5_first, k5_last, k5_out_valid, k5_sat;
  logic [199:0]       k5_feature, k5_kernel;
  logic signed [31:0] k5_bias, k5_result;

  // ACC_WIDTH=20 instance
  logic               a_valid, a_in_ready, a_first, a_last, a_out_valid, a_sat;
  logic [71:0]        a_feature, a_kernel;
  logic signed [19:0] a_bias, a_result;

  mac_pipelined #(.KERNEL_SIZE(3), .DATA_WIDTH(8), .ACC_WIDTH(32)) u_dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_first(in_first), .in_last(in_last), .feature(feature), .kernel(kernel),
    .bias(bias), .out_valid(out_valid), .out_ready(out_ready),
    .result(result), .out_sat(out_sat)
  );

  mac_pipelined #(.KERNEL_SIZE(5), .DATA_WIDTH(8), .ACC_WIDTH(32)) u_k5 (
    .clk(clk), .rst(rst), .in_valid(k5_valid), .in_ready(k5_in_ready),
    .in_first(k5_first), .in_last(k5_last), .feature(k5_feature), .kernel(k5_kernel),
    .bias(k5_bias), .out_valid(k5_out_valid), .out_ready(1'b1),
    .result(k5_result), .out_sat(k5_sat)
  );

  mac_pipelined #(.KERNEL_SIZE(3), .DATA_WIDTH(8), .ACC_WIDTH(20)) u_a20 (
    .clk(clk), .rst(rst), .in_valid(a_valid), .in_ready(a_in_ready),
    .in_first(a_first), .in_last(a_last), .feature(a_feature), .kernel(a_kernel),
    .bias(a_bias), .out_valid(a_out_valid), .out_ready(1'b1),
    .result(a_result), .out_sat(a_sat)
  );

  typedef struct { int r; bit s; int c; } obs_t;
  obs_t q_main[$];
  obs_t q_k5[$];
  obs_t q_a20[$];

  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) q_main.push_back('{int'(result), out_sat, cyc});
    if (!rst && k5_out_valid) q_k5.push_back('{int'(k5_result), k5_sat, cyc});
    if (!rst && a_out_valid) q_a20.push_back('{int'(a_result), a_sat, cyc});
  end

  typedef struct {
    bit first; bit last; int fb; int fs; int w; int b;
    bit eo; int er; bit es;
  } vec_t;
  vec_t vecs[10];

  task automatic chk(input string name, input logic signed [63:0] act, input logic signed [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual %0d required %0d", name, act, exp);
    end
  endtask

  function automatic logic [71:0] pat3(input int base, input int step);
    logic [71:0] v;
    for (int i = 0; i < 9; i++) v[i*8 +: 8] = 8'(base + i * step);
    return v;
  endfunction

  function automatic logic [199:0] pat5(input int base);
    logic [199:0] v;
    for (int i = 0; i < 25; i++) v[i*8 +: 8] = 8'(base);
    return v;
  endfunction

  task automatic send(input bit first, input bit last, input int fb, input int fs, input int w, input int b);
    in_first = first;
    in_last  = last;
    feature  = pat3(fb, fs);
    kernel   = pat3(w, 0);
    bias     = 32'(b);
    in_valid = 1'b1;
    for (int n = 0; n < 20; n++) begin
      @(negedge clk);
      if (in_ready) break;
    end
    chk("send_accept", in_ready, 1);
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    in_valid = 0; in_first = 0; in_last = 0; feature = '0; kernel = '0; bias = '0; out_ready = 1'b1;
    k5_valid = 0; k5_first = 0; k5_last = 0; k5_feature = '0; k5_kernel = '0; k5_bias = '0;
    a_valid = 0; a_first = 0; a_last = 0; a_feature = '0; a_kernel = '0; a_bias = '0;

    vecs[0] = '{1, 1, 1,   0, 1,    0,    1, 9,       0};
    vecs[1] = '{1, 0, 255, 0, -128, 0,    0, 0,       0};
    vecs[2] = '{0, 0, 255, 0, -128, 0,    0, 0,       0};
    vecs[3] = '{0, 1, 255, 0, -128, 0,    1, -881280, 0};
    vecs[4] = '{1, 1, 1,   1, 1,    1000, 1, 1045,    0};
    vecs[5] = '{1, 0, 1,   1, -1,   -5,   0, 0,       0};
    vecs[6] = '{0, 1, 2,   0, 3,    999,  1, 4,       0};
    vecs[7] = '{0, 1, 10,  0, 10,   777,  1, 900,     0};
    vecs[8] = '{1, 0, 100, 0, 100,  1,    0, 0,       0};
    vecs[9] = '{1, 1, 0,   0, 0,    -7,   1, -7,      0};

    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("reset_out_valid", out_valid, 0);
    chk("reset_result", result, 0);
    chk("reset_out_sat", out_sat, 0);
    chk("reset_in_ready", in_ready, 1);
    @(posedge clk); #1;

    // latency of a single-channel group
    send(1, 1, 1, 0, 1, 0);
    @(negedge clk);
    @(negedge clk);
    chk("latency_early", out_valid, 0);
    @(negedge clk);
    chk("latency_valid", out_valid, 1);
    chk("latency_result", result, 9);
    chk("latency_sat", out_sat, 0);
    repeat (3) @(posedge clk); #1;
    q_main.delete();

    // table vectors, back to back
    for (int i = 0; i < 10; i++)
      send(vecs[i].first, vecs[i].last, vecs[i].fb, vecs[i].fs, vecs[i].w, vecs[i].b);
    repeat (8) @(posedge clk); #1;
    chk("table_count", q_main.size(), 6);
    begin
      int k;
      k = 0;
      for (int i = 0; i < 10; i++) begin
        if (vecs[i].eo && k < q_main.size()) begin
          chk($sformatf("table_result_%0d", i), q_main[k].r, vecs[i].er);
          chk($sformatf("table_sat_%0d", i), q_main[k].s, vecs[i].es);
          k++;
        end
      end
    end
    q_main.delete();

    // backpressure with three groups in flight and a fourth waiting
    out_ready = 1'b0;
    send(1, 1, 1, 0, 1, 1);
    send(1, 1, 2, 0, 1, 0);
    send(1, 1, 1, 0, -1, 0);
    in_first = 1; in_last = 1; feature = pat3(3, 0); kernel = pat3(2, 0); bias = '0; in_valid = 1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("stall_in_ready", in_ready, 0);
      chk("stall_out_valid", out_valid, 1);
    end
    chk("stall_hold_result", result, 10);
    @(posedge clk); #1;
    out_ready = 1'b1;
    send(1, 1, 3, 0, 2, 0);
    repeat (8) @(posedge clk); #1;
    chk("stall_count", q_main.size(), 4);
    if (q_main.size() == 4) begin
      chk("stall_r0", q_main[0].r, 10);
      chk("stall_r1", q_main[1].r, 18);
      chk("stall_r2", q_main[2].r, -9);
      chk("stall_r3", q_main[3].r, 54);
    end
    q_main.delete();

    // abandoned group, restart, then reset with a last beat still in flight
    send(1, 0, 5, 0, 5, 3);
    send(0, 0, 5, 0, 5, 0);
    send(1, 0, 7, 0, 7, 0);
    send(0, 1, 1, 0, 1, 0);
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("post_reset_idle", out_valid, 0);
    end
    @(posedge clk); #1;
    send(1, 1, 4, 0, -3, -100);
    repeat (8) @(posedge clk); #1;
    chk("reset_group_count", q_main.size(), 1);
    if (q_main.size() >= 1) chk("reset_group_result", q_main[0].r, -208);

    // K=5: four single-channel groups on consecutive cycles
    k5_first = 1; k5_last = 1; k5_feature = pat5(255); k5_kernel = pat5(127); k5_bias = 100;
    for (int i = 0; i < 4; i++) begin
      k5_valid = 1'b1;
      @(negedge clk);
      chk("k5_in_ready", k5_in_ready, 1);
      @(posedge clk); #1;
    end
    k5_valid = 1'b0;
    repeat (8) @(posedge clk); #1;
    chk("k5_count", q_k5.size(), 4);
    for (int i = 0; i < 4 && i < q_k5.size(); i++) begin
      chk("k5_result", q_k5[i].r, 809725);
      chk("k5_sat", q_k5[i].s, 0);
      chk("k5_consecutive", q_k5[i].c - q_k5[0].c, i);
    end

    // ACC_WIDTH=20: five channels clamp, then a clean zero group
    a_feature = pat3(255, 0); a_kernel = pat3(127, 0); a_bias = '0;
    for (int i = 0; i < 5; i++) begin
      a_first = (i == 0); a_last = (i == 4); a_valid = 1'b1;
      @(posedge clk); #1;
    end
    a_first = 1; a_last = 1; a_feature = '0; a_kernel = '0; a_bias = '0;
    @(posedge clk); #1;
    a_valid = 1'b0;
    repeat (8) @(posedge clk); #1;
    chk("a20_count", q_a20.size(), 2);
    if (q_a20.size() == 2) begin
      chk("a20_sat_result", q_a20[0].r, 524287);
      chk("a20_sat_flag", q_a20[0].s, 1);
      chk("a20_next_result", q_a20[1].r, 0);
      chk("a20_next_flag", q_a20[1].s, 0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
